// File: rtl/reset_vote_sync_if.sv
// Signal bundle for the triplicated reset voter: reset requests and error clear
// flow in, and the voted reset, ready and vote-health indications flow out.
interface reset_vote_sync_if #(
  parameter int ERR_W = 8
);
  logic             rstA;
  logic             rstB;
  logic             rstC;
  logic             clrErr;
  logic             rstOut;
  logic             ready;
  logic             voteErr;
  logic [ERR_W-1:0] errCnt;

  modport master (
    output rstA, rstB, rstC, clrErr,
    input  rstOut, ready, voteErr, errCnt
  );

  modport slave (
    input  rstA, rstB, rstC, clrErr,
    output rstOut, ready, voteErr, errCnt
  );
endinterface

// File: rtl/reset_vote_sync.sv
// Synchronizes three redundant reset requests, majority-votes them and emits a
// stretched reset plus a ready flag; disagreements are flagged and counted.
module reset_vote_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int ERR_W       = 8
) (
  input logic              clk,
  input logic              rstn,
  reset_vote_sync_if.slave bus
);

  typedef enum logic [1:0] {ST_ASSERT, ST_STRETCH, ST_RUN} state_t;

  localparam logic [7:0] LAST = 8'(STRETCH - 1);

  logic [2:0]                  req;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic                        s_a, s_b, s_c;
  logic                        vote, mismatch;

  state_t           state, state_d;
  logic [7:0]       cnt, cnt_d;
  logic             rst_out_q, ready_q, vote_err_q;
  logic [ERR_W-1:0] err_cnt;

  assign req = {bus.rstC, bus.rstB, bus.rstA};

  // Flops preset to 1 so the block powers up with reset requested on all copies.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      for (int i = 0; i < 3; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], req[i]};
    end
  end

  assign s_a      = sync_q[0][SYNC_STAGES-1];
  assign s_b      = sync_q[1][SYNC_STAGES-1];
  assign s_c      = sync_q[2][SYNC_STAGES-1];
  assign vote     = (s_a & s_b) | (s_a & s_c) | (s_b & s_c);
  assign mismatch = !((s_a == s_b) && (s_b == s_c));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_ASSERT;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_ASSERT: begin
        if (!vote) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end
      end
      ST_STRETCH: begin
        if (vote) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (cnt == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      ST_RUN: begin
        if (vote) state_d = ST_ASSERT;
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_out_q  <= 1'b1;
      ready_q    <= 1'b0;
      vote_err_q <= 1'b0;
      err_cnt    <= '0;
    end else begin
      rst_out_q  <= (state_d != ST_RUN);
      ready_q    <= (state_d == ST_RUN);
      vote_err_q <= mismatch;
      if (bus.clrErr)
        err_cnt <= '0;
      else if (mismatch && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.rstOut  = rst_out_q;
  assign bus.ready   = ready_q;
  assign bus.voteErr = vote_err_q;
  assign bus.errCnt  = err_cnt;

endmodule

// File: tb/tb_reset_vote_sync.sv
// Bench for reset_vote_sync: two configurations driven by the same stimulus and
// checked every cycle against a quiet-time/delay-line model, plus directed literals.
module tb_reset_vote_sync;

  logic clk = 1'b0, clk_en = 1'b1, rstn = 1'b1;
  logic ra = 1'b0, rb = 1'b0, rc = 1'b0, clr = 1'b0;
  int   checks = 0, errors = 0;

  always #5 if (clk_en) clk = ~clk;

  reset_vote_sync_if #(.ERR_W(8)) b0 ();
  reset_vote_sync_if #(.ERR_W(2)) b1 ();

  assign b0.rstA = ra;  assign b0.rstB = rb;  assign b0.rstC = rc;  assign b0.clrErr = clr;
  assign b1.rstA = ra;  assign b1.rstB = rb;  assign b1.rstC = rc;  assign b1.clrErr = clr;

  reset_vote_sync #(.SYNC_STAGES(2), .STRETCH(16), .ERR_W(8)) dut0 (
    .clk(clk), .rstn(rstn), .bus(b0.slave));
  reset_vote_sync #(.SYNC_STAGES(3), .STRETCH(5), .ERR_W(2)) dut1 (
    .clk(clk), .rstn(rstn), .bus(b1.slave));

  // Model: a copy's synchronized value is its input as sampled SYNC_STAGES edges
  // earlier; rstOut drops once the vote has been 0 for STRETCH+1 consecutive edges.
  function automatic int ss(int i);   return (i == 0) ? 2 : 3;   endfunction
  function automatic int st(int i);   return (i == 0) ? 16 : 5;  endfunction
  function automatic int cmax(int i); return (i == 0) ? 255 : 3; endfunction

  bit hist [2][3][4];
  int quiet [2];
  bit m_verr [2];
  int m_cnt [2];

  always @(posedge clk or negedge rstn) begin
    bit vin [3];
    int n1;
    bit mm;
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 3; c++)
          for (int k = 0; k < 4; k++) hist[i][c][k] = 1'b1;
        quiet[i]  = 0;
        m_verr[i] = 1'b0;
        m_cnt[i]  = 0;
      end
    end else begin
      vin[0] = ra; vin[1] = rb; vin[2] = rc;
      for (int i = 0; i < 2; i++) begin
        n1 = 0;
        for (int c = 0; c < 3; c++) n1 += int'(hist[i][c][ss(i)-1]);
        mm = (n1 != 0) && (n1 != 3);
        quiet[i]  = (n1 >= 2) ? 0 : ((quiet[i] < 1000) ? quiet[i] + 1 : quiet[i]);
        m_verr[i] = mm;
        if (clr) m_cnt[i] = 0;
        else if (mm && m_cnt[i] < cmax(i)) m_cnt[i] = m_cnt[i] + 1;
        for (int c = 0; c < 3; c++) begin
          for (int k = 3; k > 0; k--) hist[i][c][k] = hist[i][c][k-1];
          hist[i][c][0] = vin[c];
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input int i, input logic ro, input logic rd,
                         input logic ve, input int ec);
    bit exp_rst;
    exp_rst = (quiet[i] < st(i) + 1);
    check($sformatf("d%0d_rstOut", i),  int'(ro), int'(exp_rst));
    check($sformatf("d%0d_ready", i),   int'(rd), int'(!exp_rst));
    check($sformatf("d%0d_voteErr", i), int'(ve), int'(m_verr[i]));
    check($sformatf("d%0d_errCnt", i),  ec, m_cnt[i]);
  endtask

  always @(posedge clk) begin
    #1;
    cmp_one(0, b0.rstOut, b0.ready, b0.voteErr, int'(b0.errCnt));
    cmp_one(1, b1.rstOut, b1.ready, b1.voteErr, int'(b1.errCnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit lvl, drop;
    #1 rstn = 1'b0;
    repeat (3) step();
    check("rst_rstOut", int'(b0.rstOut), 1);
    check("rst_ready",  int'(b0.ready), 0);
    check("rst_voteErr", int'(b0.voteErr), 0);
    check("rst_errCnt", int'(b0.errCnt), 0);

    // Power-up release with all requests low.
    rstn = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 8)  check("pu_d1_e8_rstOut", int'(b1.rstOut), 1);
      if (k == 9)  check("pu_d1_e9_rstOut", int'(b1.rstOut), 0);
      if (k == 18) begin
        check("pu_e18_rstOut", int'(b0.rstOut), 1);
        check("pu_e18_ready",  int'(b0.ready), 0);
      end
      if (k == 19) begin
        check("pu_e19_rstOut", int'(b0.rstOut), 0);
        check("pu_e19_ready",  int'(b0.ready), 1);
      end
    end
    repeat (3) step();

    // Two-of-three pulse for one cycle.
    ra = 1; rb = 1; step();
    ra = 0; rb = 0; step();
    step();
    check("pulse_e3_rstOut", int'(b0.rstOut), 1);
    check("pulse_e3_voteErr", int'(b0.voteErr), 1);
    check("pulse_e3_errCnt", int'(b0.errCnt), 1);
    step();
    check("pulse_e4_voteErr", int'(b0.voteErr), 0);
    check("pulse_e4_errCnt", int'(b0.errCnt), 1);
    for (int k = 5; k <= 20; k++) begin
      step();
      if (k == 19) check("pulse_e19_rstOut", int'(b0.rstOut), 1);
      if (k == 20) check("pulse_e20_rstOut", int'(b0.rstOut), 0);
    end

    // Single disagreeing copy for 5 cycles.
    clr = 1; step(); clr = 0;
    check("clr_errCnt", int'(b0.errCnt), 0);
    rc = 1; n = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (b0.voteErr) n++;
      if (k == 5) rc = 0;
    end
    check("single_verr_cycles", n, 5);
    check("single_errCnt", int'(b0.errCnt), 5);
    check("single_d1_sat", int'(b1.errCnt), 3);
    check("single_ready", int'(b0.ready), 1);

    // rstB alone for 6 cycles; then clear against a live mismatch.
    clr = 1; step(); clr = 0;
    rb = 1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 6) rb = 0;
    end
    check("sat_d0_errCnt", int'(b0.errCnt), 6);
    check("sat_d1_errCnt", int'(b1.errCnt), 3);
    rb = 1; step(); step(); step();
    clr = 1; step();
    check("clrpri_d0_errCnt", int'(b0.errCnt), 0);
    check("clrpri_d1_errCnt", int'(b1.errCnt), 0);
    check("clrpri_d0_voteErr", int'(b0.voteErr), 1);
    clr = 0; step();
    check("clrpri_d0_after", int'(b0.errCnt), 1);
    check("clrpri_d1_after", int'(b1.errCnt), 1);
    rb = 0;
    repeat (10) step();

    // Release, reassert mid-stretch, then a full release.
    ra = 1; rb = 1; rc = 1;
    repeat (6) step();
    ra = 0; rb = 0; rc = 0; drop = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 9) begin ra = 1; rb = 1; rc = 1; end
      if (!b0.rstOut) drop = 1;
    end
    check("reassert_no_drop", int'(drop), 0);
    ra = 0; rb = 0; rc = 0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 18) check("rerel_e18_rstOut", int'(b0.rstOut), 1);
      if (k == 19) check("rerel_e19_rstOut", int'(b0.rstOut), 0);
    end

    // Randomized phase with occasional asynchronous block resets.
    lvl = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      if ($urandom_range(0, 29) == 0) lvl = ~lvl;
      ra  = lvl ^ ($urandom_range(0, 9) == 0);
      rb  = lvl ^ ($urandom_range(0, 9) == 0);
      rc  = lvl ^ ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rstn = 0;
        #3 rstn = 1;
      end
    end
    clr = 0;

    // Asynchronous reset mid-stretch with the clock stopped.
    ra = 1; rb = 1; rc = 0;
    repeat (6) step();
    ra = 0; rb = 0;
    repeat (11) step();
    check("midstr_rstOut_pre", int'(b0.rstOut), 1);
    @(negedge clk);
    clk_en = 0;
    #3 rstn = 0;
    #1;
    check("async_rstOut", int'(b0.rstOut), 1);
    check("async_ready",  int'(b0.ready), 0);
    check("async_errCnt", int'(b0.errCnt), 0);
    check("async_voteErr", int'(b0.voteErr), 0);
    check("async_d1_rstOut", int'(b1.rstOut), 1);
    check("async_d1_errCnt", int'(b1.errCnt), 0);
    #20 rstn = 1;
    #2 clk_en = 1;
    repeat (25) step();
    check("restart_rstOut", int'(b0.rstOut), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_vote_sync.md
RESET_VOTE_SYNC -- requirements
Module: reset_vote_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth per reset copy (legal range 2..4).
REQ-002 Parameter STRETCH, default 16, cycles the voted reset is held after release (legal range 1..255).
REQ-003 Parameter ERR_W, default 8, width of the vote-mismatch counter.
REQ-004 clk  input  1  single block clock; all flops on rising edge.
REQ-005 rstn  input  1  block reset; asynchronous, active-low.
REQ-006 rstA / rstB / rstC  input  1 each  triplicated reset requests, active-high, asynchronous to clk.
REQ-007 clrErr  input  1  synchronous clear of errCnt, active-high.
REQ-008 rstOut  output  1  voted, synchronized, stretched reset, active-high, registered.
REQ-009 ready  output  1  high only in RUN state, registered.
REQ-010 voteErr  output  1  registered flag; high while the three synchronized copies disagree.
REQ-011 errCnt  output  ERR_W  saturating count of mismatch cycles.

Function
REQ-012 Each of rstA/B/C passes through its own SYNC_STAGES-flop synchronizer; synchronized copies are sA/sB/sC.
REQ-013 vote = majority(sA,sB,sC); mismatch = copies not all equal (combinational).
REQ-014 FSM states ASSERT, STRETCH, RUN; rstOut=1 in ASSERT and STRETCH, 0 in RUN; ready=1 only in RUN; both are registered decodes of the next state.
REQ-015 ASSERT: vote=0 -> STRETCH with stretch counter = 0; otherwise stay.
REQ-016 STRETCH: vote=1 -> ASSERT (counter discarded); else counter increments; counter = STRETCH-1 -> RUN on the next edge; total STRETCH cycles spent in STRETCH.
REQ-017 RUN: vote=1 -> ASSERT; otherwise stay.
REQ-018 Assertion latency: a majority of inputs rising before edge 0 gives rstOut=1 after edge SYNC_STAGES+1.
REQ-019 Release latency: a majority of inputs falling before edge 0 gives rstOut=0 after edge SYNC_STAGES+1+STRETCH.
REQ-020 A single disagreeing copy never changes rstOut or the FSM state.
REQ-021 voteErr is registered from mismatch: one cycle behind the synchronized copies.
REQ-022 errCnt increments by 1 on each edge where mismatch=1; it saturates at 2^ERR_W-1 and does not wrap.
REQ-023 clrErr=1 sets errCnt to 0 on that edge and takes priority over a simultaneous increment.
REQ-024 The stretch counter is 8 bits wide; it is only meaningful in STRETCH and resets to 0 on leaving that state.

Reset
REQ-025 rstn=0 immediately and asynchronously sets the following, regardless of clk:
- all synchronizer flops to 1;
- FSM to ASSERT;
- rstOut=1, ready=0, voteErr=0, errCnt=0, stretch counter 0.
REQ-026 rstn deassertion mid-operation restarts from ASSERT. rstOut can fall no earlier than SYNC_STAGES+1+STRETCH edges after both rstn=1 and a majority of inputs=0.

Verification
REQ-027 Power-up (defaults): rstn low then high, rstA/B/C=0 throughout.
-> rstOut=1, ready=0 until edge 19 after rstn release.
-> rstOut=0, ready=1 after edge 19.
REQ-028 In RUN, rstA=rstB=1 pulsed for 1 cycle, rstC=0.
-> rstOut=1 after edge 3.
-> voteErr=1 for 1 cycle, errCnt=1.
-> rstOut=0 again 19 edges after the inputs fall.
REQ-029 In RUN, only rstC=1 for 5 cycles.
-> rstOut and ready unchanged.
-> voteErr=1 for 5 cycles, errCnt=5.
REQ-030 Majority released, then reasserted at STRETCH cycle 8.
-> FSM returns to ASSERT.
-> rstOut never drops.
-> A later release needs the full 16 stretch cycles.
REQ-031 ERR_W=2, rstB held alone high for 6 cycles.
-> errCnt saturates at 3.
-> clrErr together with mismatch gives errCnt=0 on that edge.
REQ-032 rstn asserted mid-STRETCH with clk stopped.
-> rstOut=1, ready=0 immediately.
-> errCnt=0.
